// File: rtl/load_store_unit.sv
// rv32i load/store unit: one LOAD/STORE at a time over a req/gnt/rvalid data bus.
// Define LSU_ALIGN_CHECK_EN to turn misaligned halfword/word accesses into errors.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_n;

    logic              accept;
    logic              is_byte;
    logic              is_half;
    logic              illegal;
    logic              misaligned;
    logic              req_err;
    logic [3:0]        be_n;
    logic [DATA_W-1:0] wdata_n;

    logic              store_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ext;

    assign req_ready = (state == IDLE);
    assign accept    = req_ready && req_valid;

    always_comb begin
        is_byte = (req_funct3[1:0] == 2'b00);
        is_half = (req_funct3[1:0] == 2'b01);
        if (req_store) begin
            illegal = (req_funct3 >= 3'd3);
        end else begin
            illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
`ifdef LSU_ALIGN_CHECK_EN
        misaligned = (is_half && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        req_err = illegal || misaligned;
        be_n    = 4'b1111;
        wdata_n = req_wdata;
        unique case (1'b1)
            is_byte: begin
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            is_half: begin
                be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane pick uses the captured byte offset; halfwords only look at bit 1.
    always_comb begin
        byte_v = mem_rdata[{off_q, 3'b000} +: 8];
        half_v = mem_rdata[{off_q[1], 4'b0000} +: 16];
        ext    = mem_rdata;
        unique case (f3_q[1:0])
            2'b00: begin
                ext = f3_q[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                ext = f3_q[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (req_valid) state_n = req_err ? RESP : REQ;
            REQ:  if (mem_gnt) state_n = store_q ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_n = RESP;
            RESP: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= 5'd0;
            resp_error <= 1'b0;
            store_q    <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
        end else begin
            mem_req    <= (state_n == REQ);
            resp_valid <= (state_n == RESP);
            if (accept) begin
                store_q    <= req_store;
                f3_q       <= req_funct3;
                off_q      <= req_addr[1:0];
                resp_rd    <= req_rd;
                resp_error <= req_err;
                resp_rdata <= '0;
                if (!req_err) begin
                    mem_we    <= req_store;
                    mem_be    <= be_n;
                    mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata <= wdata_n;
                end
            end
            if (state == WAIT && mem_rvalid) begin
                resp_rdata <= ext;
            end
        end
    end

endmodule
